// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg                                                                 |
// | Shared UART definitions: link defaults, RX state encoding, sizing helper.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package uart_pkg;

  // 100 MHz system clock at 115200 baud; the TX path uses the same default.
  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int DATA_BITS_DEFAULT    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_sync                                                             |
// | Two-flop synchroniser for the serial line plus a falling-edge detector.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_q;

  // Reset to the idle-high level so leaving reset never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta   <= rx_i;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign rx_s = sync;
  assign fall = sync_q & ~sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx                                                                  |
// | 8N1-style UART receiver: mid-bit sampling, LSB-first deserialisation,    |
// | held-valid/ack output with framing and overrun pulses.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en,
  input  logic                 rx_i,
  input  logic                 rx_ack_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  logic                 rx_s;
  logic                 fall;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CW-1:0]        baud_cnt;
  logic [CW-1:0]        baud_cnt_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 load;
  logic                 ferr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;

  uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    load         = 1'b0;
    ferr         = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_cnt_nxt = '0;
        if (fall) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_nxt = '0;
          state_nxt    = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          shreg_nxt    = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == BITS_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is never missed.
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          state_nxt    = ST_IDLE;
          load         = rx_s;
          ferr         = ~rx_s;
        end
      end
      default: begin
        baud_cnt_nxt = '0;
        state_nxt    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (en) begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      ferr_q   <= ferr;
      ovr_q    <= load & valid_q & ~rx_ack_i;
      // A completing byte wins over a same-cycle ack.
      if (load) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
      end else if (rx_ack_i) begin
        valid_q <= 1'b0;
      end
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q & en;
  assign overrun_o   = ovr_q & en;
  assign busy_o      = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx                                                               |
// | Scoreboard bench for uart_rx at 16 clocks per bit.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int CPB      = 16;
  localparam int FRAME_V  = 10 * CPB;
  localparam int BUSY_LEN = CPB / 2 + 9 * CPB;
  localparam int DONE_V   = 3 + BUSY_LEN;
  localparam int FREEZE   = 20;

  localparam int K_BYTE   = 0;
  localparam int K_ERR    = 1;
  localparam int K_GLITCH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en          (en),
    .rx_i        (rx),
    .rx_ack_i    (ack),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       valid;
    logic       ovr;
    int         blen;
  } ev_t;

  ev_t        sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every busy fall is one frame outcome owed by the scoreboard.
  logic prev_busy = 1'b0;
  int   blen      = 0;
  bit   chk_next  = 1'b0;
  ev_t  ev;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      blen      = 0;
      chk_next  = 1'b0;
    end else begin
      if (chk_next) begin
        check("pulse_width", {30'd0, frame_err, overrun}, 32'd0);
        chk_next = 1'b0;
      end
      if (!en) check("pulse_en_low", {30'd0, frame_err, overrun}, 32'd0);
      if (busy) blen++;
      if (prev_busy && !busy) begin
        check("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          ev = sb.pop_front();
          check("busy_len", blen, ev.blen);
          check("rx_data", rx_data, ev.data);
          check("rx_valid", rx_valid, ev.valid);
          check("frame_err", frame_err, ev.kind == K_ERR);
          check("overrun", overrun, ev.ovr);
          chk_next = 1'b1;
        end
        blen = 0;
      end
      prev_busy = busy;
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    #1;
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    m_data  = 8'h00;
    m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    m_valid = 1'b0;
    check("ack_clear", rx_valid, 0);
  endtask

  task automatic send_glitch();
    ev_t e;
    e.kind = K_GLITCH; e.data = m_data; e.valid = m_valid; e.ovr = 1'b0; e.blen = CPB / 2;
    sb.push_back(e);
    rx = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rx = 1'b1;
    repeat (2 * CPB) begin @(posedge clk); #1; end
  endtask

  // v counts enabled edges only, so a freeze stretches the current bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit ack_end,
                            input int freeze_at, input int abort_at);
    logic [9:0] fr;
    int         v;
    int         hold;
    ev_t        e;
    fr   = {stop, d, 1'b0};
    v    = 0;
    hold = 0;
    if (abort_at < 0) begin
      e.kind = stop ? K_BYTE : K_ERR;
      e.blen = BUSY_LEN + ((freeze_at >= 0) ? FREEZE : 0);
      if (stop) begin
        e.ovr   = m_valid && !ack_end;
        m_data  = d;
        m_valid = 1'b1;
      end else begin
        e.ovr = 1'b0;
      end
      e.data  = m_data;
      e.valid = m_valid;
      sb.push_back(e);
    end
    rx = fr[0];
    while (v < FRAME_V) begin
      en  = !(freeze_at >= 0 && v == freeze_at && hold < FREEZE);
      ack = ack_end && en && (v == DONE_V - 1);
      @(posedge clk); #1;
      if (en) v++; else hold++;
      if (abort_at >= 0 && v == abort_at) begin
        do_reset();
        return;
      end
      rx = (v < FRAME_V) ? fr[v / CPB] : 1'b1;
    end
    en  = 1'b1;
    ack = 1'b0;
    rx  = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    repeat (4) begin @(posedge clk); #1; end

    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    do_ack();
    send_glitch();

    send_frame(8'h11, 1'b1, 1'b0, -1, -1);
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    do_ack();

    send_frame(8'h55, 1'b1, 1'b0, -1, -1);
    send_frame(8'hAA, 1'b1, 1'b0, -1, -1);
    do_ack();
    send_frame(8'h55, 1'b1, 1'b0, -1, -1);
    send_frame(8'hAA, 1'b1, 1'b1, -1, -1);

    // Reset lands inside data bit 4 while a byte is still held valid.
    send_frame(8'hFF, 1'b1, 1'b0, -1, 3 + CPB / 2 + 4 * CPB + 5);
    repeat (4) begin @(posedge clk); #1; end
    send_frame(8'h81, 1'b1, 1'b0, -1, -1);
    do_ack();

    send_frame(8'h6E, 1'b1, 1'b0, 3 * CPB + 12, -1);
    do_ack();

    for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge clk);
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
